gray_counter: RTL

Parametrised registered binary/Gray up/down counter with synchronous load, wrap or saturate mode, and boundary flags. It is the sequential successor to the combinational bin2gray/gray2bin pair. It is the pointer generator for the async FIFO: gray_out crosses clock domains and bin_out addresses local RAM. Binary and Gray outputs are both registered, so gray_out is glitch-free.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/bin2gray.sv | 13 +
 rtl/gray_counter.sv | 98 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers for the Gray-code counter.
//   bin2gray_f - binary to Gray (b ^ (b >> 1)), arguments up to 32 bits,
//                zero-extended by the caller.
//   gray2bin_f - Gray to binary by prefix XOR from the MSB down.
//   MODE_WRAP / MODE_SAT - values for the counter's SATURATE parameter.
package gray_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [31:0] bin2gray_f(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin_f(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// bin2gray: purely combinational binary to Gray converter.
//   bin  - N-bit binary input
//   gray - N-bit Gray code of bin
module bin2gray #(
    parameter int N = 8
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered binary/Gray up/down counter with synchronous load,
// wrap or saturate mode and registered boundary flags. Used as a FIFO pointer:
// gray_out is safe to synchronise into another clock domain because it comes
// straight from a flop and changes one bit per counting step.
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset to RST_VAL
//   en       - step enable
//   up_dn    - step direction, 1 = +1, 0 = -1 (only looked at when en = 1)
//   load     - synchronous load strobe, beats en
//   load_bin - binary value loaded when load = 1
//   bin_out  - registered binary count
//   gray_out - registered Gray code of bin_out
//   at_max   - bin_out == 2^N-1
//   at_min   - bin_out == 0
//   wrap     - one-cycle pulse after a step crossed 2^N-1 <-> 0 (wrap mode)
// Width is limited to N <= 32 by the package helpers used for the reset code.
module gray_counter
    import gray_pkg::*;
#(
    parameter int           N        = 8,
    parameter int           SATURATE = MODE_WRAP,
    parameter logic [N-1:0] RST_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         at_max,
    output logic         at_min,
    output logic         wrap
);

    localparam logic [N-1:0] MAX_VAL  = {N{1'b1}};
    localparam logic [N-1:0] MIN_VAL  = {N{1'b0}};
    localparam logic [N-1:0] RST_GRAY = N'(bin2gray_f(32'(RST_VAL)));
    localparam bit           SAT_MODE = (SATURATE == MODE_SAT);

    logic [N-1:0] bin_next;
    logic [N-1:0] gray_next;
    logic         wrap_next;

    // Next count: load > step > hold. In saturate mode a step past either end
    // is simply dropped, so the count (and its Gray code) does not move.
    always_comb begin
        bin_next  = bin_out;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (bin_out == MAX_VAL) begin
                    if (!SAT_MODE) begin
                        bin_next  = MIN_VAL;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_out + 1'b1;
                end
            end else begin
                if (bin_out == MIN_VAL) begin
                    if (!SAT_MODE) begin
                        bin_next  = MAX_VAL;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_out - 1'b1;
                end
            end
        end
    end

    // Gray code is formed from bin_next so both outputs load on the same edge.
    bin2gray #(.N(N)) u_bin2gray (
        .bin  (bin_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out  <= RST_VAL;
            gray_out <= RST_GRAY;
            at_max   <= (RST_VAL == MAX_VAL);
            at_min   <= (RST_VAL == MIN_VAL);
            wrap     <= 1'b0;
        end else begin
            bin_out  <= bin_next;
            gray_out <= gray_next;
            at_max   <= (bin_next == MAX_VAL);
            at_min   <= (bin_next == MIN_VAL);
            wrap     <= wrap_next;
        end
    end

endmodule
